// File: rtl/alarm_fsm_if.sv
// Alarm controller bus: sensor inputs, 1 Hz tick, parameter-bank return path
// and the controller outputs.
//   master : sensor/bank/test side (drives sensors, tick, value; reads outputs)
//   slave  : alarm_fsm side (reads sensors, tick, value; drives outputs)
interface alarm_fsm_if #(
  parameter int CNT_W = 4
);
  logic             ignition;
  logic             door_driver;
  logic             door_pass;
  logic             reprogram;
  logic             one_hz_enable;
  logic [CNT_W-1:0] value;
  logic [1:0]       interval;
  logic             siren;
  logic             status;
  logic [2:0]       state_dbg;
  logic [CNT_W-1:0] countdown;

  modport master (
    output ignition, door_driver, door_pass, reprogram, one_hz_enable, value,
    input  interval, siren, status, state_dbg, countdown
  );

  modport slave (
    input  ignition, door_driver, door_pass, reprogram, one_hz_enable, value,
    output interval, siren, status, state_dbg, countdown
  );
endinterface

// File: rtl/alarm_fsm.sv
// Car anti-theft alarm controller.
// Runs the arm / trigger / siren / disarm state machine from the ignition and
// door sensors and sequences the stored delay bank: `interval` selects the
// active delay, the selected `value` is loaded one cycle later and counted
// down on 1 Hz ticks.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : alarm_fsm_if.slave (sensors, tick, delay value in; interval,
//           siren, status LED, debug state and countdown out)
module alarm_fsm #(
  parameter int CNT_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  alarm_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    S_ARMED      = 3'd0,
    S_TRIGGERED  = 3'd1,
    S_SOUND      = 3'd2,
    S_DISARMED   = 3'd3,
    S_WAIT_OPEN  = 3'd4,
    S_WAIT_CLOSE = 3'd5,
    S_ARM_DELAY  = 3'd6
  } state_t;

  localparam logic [1:0] INT_ARM   = 2'b00;
  localparam logic [1:0] INT_DRV   = 2'b01;
  localparam logic [1:0] INT_PASS  = 2'b10;
  localparam logic [1:0] INT_ALARM = 2'b11;

  state_t           r_state,     w_state_nx;
  logic [1:0]       r_interval,  w_interval_nx;
  logic             r_load,      w_load_nx;
  logic             r_siren,     w_siren_nx;
  logic             r_status,    w_status_nx;
  logic [CNT_W-1:0] r_countdown, w_count_nx;

  logic w_tick;
  logic w_door;
  logic w_expire;
  logic w_ign_abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_ARMED;
      r_interval  <= INT_ARM;
      r_load      <= 1'b0;
      r_siren     <= 1'b0;
      r_status    <= 1'b0;
      r_countdown <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_interval  <= w_interval_nx;
      r_load      <= w_load_nx;
      r_siren     <= w_siren_nx;
      r_status    <= w_status_nx;
      r_countdown <= w_count_nx;
    end
  end

  always_comb begin
    w_tick        = bus.one_hz_enable;
    w_door        = bus.door_driver | bus.door_pass;
    // The load cycle swallows any tick, so the delay cannot expire there.
    // A loaded 0 expires on the first tick exactly like a loaded 1.
    w_expire      = w_tick && !r_load && (r_countdown <= CNT_W'(1));
    w_ign_abort   = bus.ignition && ((r_state == S_ARMED) || (r_state == S_TRIGGERED) ||
                                     (r_state == S_SOUND) || (r_state == S_ARM_DELAY));
    w_state_nx    = r_state;
    w_interval_nx = r_interval;
    w_load_nx     = 1'b0;

    // Counter: load has priority, otherwise saturating decrement on ticks.
    if (r_load)
      w_count_nx = bus.value;
    else if (w_tick && (r_countdown != '0))
      w_count_nx = r_countdown - CNT_W'(1);
    else
      w_count_nx = r_countdown;

    if (bus.reprogram) begin
      w_state_nx = S_ARMED;
      w_count_nx = '0;
    end else if (w_ign_abort) begin
      w_state_nx = S_DISARMED;
    end else begin
      unique case (r_state)
        S_ARMED: begin
          if (bus.door_driver) begin
            w_state_nx    = S_TRIGGERED;
            w_interval_nx = INT_DRV;
            w_load_nx     = 1'b1;
          end else if (bus.door_pass) begin
            w_state_nx    = S_TRIGGERED;
            w_interval_nx = INT_PASS;
            w_load_nx     = 1'b1;
          end
        end
        S_TRIGGERED: begin
          if (w_expire) begin
            w_state_nx    = S_SOUND;
            w_interval_nx = INT_ALARM;
            w_load_nx     = 1'b1;
          end
        end
        S_SOUND: begin
          // An open door keeps reloading, holding the alarm indefinitely.
          if (w_door)
            w_load_nx = 1'b1;
          else if (w_expire)
            w_state_nx = S_ARMED;
        end
        S_DISARMED: begin
          if (!bus.ignition)
            w_state_nx = S_WAIT_OPEN;
        end
        S_WAIT_OPEN: begin
          if (bus.ignition)
            w_state_nx = S_DISARMED;
          else if (bus.door_driver)
            w_state_nx = S_WAIT_CLOSE;
        end
        S_WAIT_CLOSE: begin
          if (bus.ignition)
            w_state_nx = S_DISARMED;
          else if (!bus.door_driver) begin
            w_state_nx    = S_ARM_DELAY;
            w_interval_nx = INT_ARM;
            w_load_nx     = 1'b1;
          end
        end
        S_ARM_DELAY: begin
          if (w_door)
            w_load_nx = 1'b1;
          else if (w_expire)
            w_state_nx = S_ARMED;
        end
        default: w_state_nx = S_ARMED;
      endcase
    end

    w_siren_nx = (w_state_nx == S_SOUND);

    // Status LED: solid while alarmed, blinking while armed. A reprogram is
    // treated as a fresh entry into ARMED, so the blink phase restarts at 0.
    if ((w_state_nx == S_TRIGGERED) || (w_state_nx == S_SOUND))
      w_status_nx = 1'b1;
    else if ((w_state_nx == S_ARMED) && (r_state == S_ARMED) && !bus.reprogram)
      w_status_nx = w_tick ? ~r_status : r_status;
    else
      w_status_nx = 1'b0;
  end

  assign bus.interval  = r_interval;
  assign bus.siren     = r_siren;
  assign bus.status    = r_status;
  assign bus.state_dbg = r_state;
  assign bus.countdown = r_countdown;

endmodule

// File: tb/tb_alarm_fsm.sv
// Testbench for alarm_fsm: directed scenarios followed by randomized sensor
// activity, all compared cycle by cycle with a behavioural model.
module tb_alarm_fsm;
  localparam int CNT_W = 4;

  localparam int ARMED = 0, TRIG = 1, SOUND = 2, DISARM = 3;
  localparam int WOPEN = 4, WCLOSE = 5, ADELAY = 6;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alarm_fsm_if #(.CNT_W(CNT_W)) bus ();

  alarm_fsm #(.CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Stored delay bank: arm, driver, passenger, alarm-on.
  int bank [4];
  always_comb bus.value = CNT_W'(bank[bus.interval]);

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_state, m_int, m_cnt, m_siren, m_status;
  bit m_pending;   // a delay has been selected and is loaded next cycle

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = ARMED; m_int = 0; m_cnt = 0; m_siren = 0; m_status = 0; m_pending = 0;
  endtask

  // One clock of the alarm rules, applied to the inputs present at the edge.
  task automatic model_step(input bit ign, input bit dd, input bit dp, input bit rp, input bit tk);
    bit door_open, timed_out, restart;
    int nxt, nxt_int, nxt_cnt;
    door_open = dd || dp;
    timed_out = tk && !m_pending && (m_cnt <= 1);
    nxt = m_state; nxt_int = m_int; restart = 0;
    if (m_pending)      nxt_cnt = bank[m_int];
    else if (tk)        nxt_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
    else                nxt_cnt = m_cnt;

    if (rp) begin
      nxt = ARMED; nxt_cnt = 0;
    end else if (ign && (m_state == ARMED || m_state == TRIG || m_state == SOUND || m_state == ADELAY)) begin
      nxt = DISARM;
    end else if (m_state == ARMED && door_open) begin
      nxt = TRIG; nxt_int = dd ? 1 : 2; restart = 1;
    end else if (m_state == TRIG && timed_out) begin
      nxt = SOUND; nxt_int = 3; restart = 1;
    end else if (m_state == SOUND || m_state == ADELAY) begin
      if (door_open) restart = 1;
      else if (timed_out) nxt = ARMED;
    end else if (m_state == DISARM) begin
      if (!ign) nxt = WOPEN;
    end else if (m_state == WOPEN || m_state == WCLOSE) begin
      if (ign) nxt = DISARM;
      else if (m_state == WOPEN && dd) nxt = WCLOSE;
      else if (m_state == WCLOSE && !dd) begin nxt = ADELAY; nxt_int = 0; restart = 1; end
    end

    if (nxt == TRIG || nxt == SOUND)                     m_status = 1;
    else if (nxt == ARMED && m_state == ARMED && !rp)    m_status = tk ? 1 - m_status : m_status;
    else                                                 m_status = 0;
    m_siren   = (nxt == SOUND) ? 1 : 0;
    m_state   = nxt;
    m_int     = nxt_int;
    m_cnt     = nxt_cnt;
    m_pending = restart;
  endtask

  task automatic compare_all();
    check_eq("state",     32'(bus.state_dbg), 32'(m_state));
    check_eq("interval",  32'(bus.interval),  32'(m_int));
    check_eq("siren",     32'(bus.siren),     32'(m_siren));
    check_eq("status",    32'(bus.status),    32'(m_status));
    check_eq("countdown", 32'(bus.countdown), 32'(m_cnt));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit ign, input bit dd, input bit dp, input bit rp, input bit tk);
    bus.ignition      = ign;
    bus.door_driver   = dd;
    bus.door_pass     = dp;
    bus.reprogram     = rp;
    bus.one_hz_enable = tk;
    @(posedge clock);
    model_step(ign, dd, dp, rp, tk);
    #1;
    compare_all();
    @(negedge clock);
  endtask

  // n ticks, each followed by an idle cycle, with the sensors held.
  task automatic ticks(input int n, input bit ign, input bit dd, input bit dp);
    for (int i = 0; i < n; i++) begin
      step(ign, dd, dp, 1'b0, 1'b1);
      step(ign, dd, dp, 1'b0, 1'b0);
    end
  endtask

  bit r_ign, r_dd, r_dp, r_rp, r_tk;

  initial begin
    bank[0] = 6; bank[1] = 8; bank[2] = 5; bank[3] = 10;
    bus.ignition = 0; bus.door_driver = 0; bus.door_pass = 0;
    bus.reprogram = 0; bus.one_hz_enable = 0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    compare_all();
    reset = 1'b0;

    // Driver door in ARMED: 8 s driver delay, then siren.
    step(0, 1, 0, 0, 0);
    check_eq("trig_interval", 32'(bus.interval), 32'd1);
    step(0, 0, 0, 0, 1);                  // load cycle, tick ignored
    check_eq("drv_loaded", 32'(bus.countdown), 32'd8);
    ticks(7, 0, 0, 0);
    check_eq("siren_before_8th", 32'(bus.siren), 32'd0);
    step(0, 0, 0, 0, 1);
    check_eq("siren_after_8th", 32'(bus.siren), 32'd1);
    check_eq("alarm_interval", 32'(bus.interval), 32'd3);

    // SOUND held by an open passenger door, then 10 s after closing.
    ticks(20, 0, 0, 1);
    check_eq("siren_held", 32'(bus.siren), 32'd1);
    step(0, 0, 0, 0, 0);                  // load cycle after closing
    ticks(9, 0, 0, 0);
    check_eq("siren_9_after_close", 32'(bus.siren), 32'd1);
    ticks(1, 0, 0, 0);
    check_eq("siren_10_after_close", 32'(bus.siren), 32'd0);
    check_eq("back_armed", 32'(bus.state_dbg), 32'd0);

    // Ignition during TRIGGERED, then the arm-delay path.
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    ticks(5, 0, 0, 0);
    check_eq("cnt_at_3", 32'(bus.countdown), 32'd3);
    step(1, 0, 0, 0, 0);
    check_eq("disarmed", 32'(bus.state_dbg), 32'd3);
    check_eq("disarm_status", 32'(bus.status), 32'd0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("arm_delay_interval", 32'(bus.interval), 32'd0);
    step(0, 0, 0, 0, 0);
    ticks(4, 0, 0, 0);
    check_eq("arm_cnt_2", 32'(bus.countdown), 32'd2);
    step(0, 0, 1, 0, 0);                  // passenger door restarts delay
    step(0, 0, 0, 0, 0);
    check_eq("arm_reload", 32'(bus.countdown), 32'd6);
    ticks(5, 0, 0, 0);
    check_eq("still_arm_delay", 32'(bus.state_dbg), 32'd6);
    ticks(1, 0, 0, 0);
    check_eq("armed_after_6", 32'(bus.state_dbg), 32'd0);

    // Passenger delay 0 expires on the first tick after loading.
    bank[2] = 0;
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_eq("zero_delay_sound", 32'(bus.state_dbg), 32'd2);
    step(0, 0, 0, 1, 0);
    check_eq("reprog_armed", 32'(bus.state_dbg), 32'd0);
    check_eq("reprog_siren", 32'(bus.siren), 32'd0);
    step(0, 1, 1, 0, 0);
    check_eq("both_doors", 32'(bus.interval), 32'd1);

    // Asynchronous reset in the middle of ARM_DELAY.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    ticks(2, 0, 0, 0);
    check_eq("pre_reset_state", 32'(bus.state_dbg), 32'd6);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b0;

    // Randomized sensor activity.
    bank[0] = 3; bank[1] = 4; bank[2] = 2; bank[3] = 5;
    r_ign = 0; r_dd = 0; r_dp = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) r_ign = ~r_ign;
      if ($urandom_range(0, 11) == 0) r_dd  = ~r_dd;
      if ($urandom_range(0, 11) == 0) r_dp  = ~r_dp;
      r_rp = ($urandom_range(0, 149) == 0);
      r_tk = ($urandom_range(0, 3) == 0);
      if (r_rp)
        for (int k = 0; k < 4; k++) bank[k] = $urandom_range(0, 9);
      step(r_ign, r_dd, r_dp, r_rp, r_tk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alarm_fsm.md
Name: alarm_fsm

Overview:
- Central controller of the car anti-theft alarm.
- Sequences the stored time-parameter bank. Drives `interval` to select which stored delay is active, then loads and counts that delay down on 1 Hz ticks.
- Runs the arm / trigger / siren / disarm state machine from ignition and door sensors.
- Sits between the sensor synchronisers and the siren and status-LED drivers; the 1 Hz divider supplies `one_hz_enable`.

Parameters:
- `CNT_W`, 4, width of the countdown counter; equals the width of `value`.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `ignition`  in  1  1 = ignition on (synchronised)
- `door_driver`  in  1  1 = driver door open (synchronised, debounced)
- `door_pass`  in  1  1 = passenger door open (synchronised, debounced)
- `reprogram`  in  1  pulse; the parameter bank is being rewritten
- `one_hz_enable`  in  1  single-cycle tick, once per second
- `value`  in  CNT_W  delay currently selected by `interval`, in seconds (combinational return path)
- `interval`  out  2  selects delay: 00 arm, 01 driver, 10 passenger, 11 alarm-on
- `siren`  out  1  siren drive
- `status`  out  1  status LED
- `state_dbg`  out  3  current state encoding, debug only
- `countdown`  out  CNT_W  current counter value, debug only

Behaviour:
- Clock and reset: single clock `clock`; reset is asynchronous and active-high, all registers on posedge `clock` or posedge `reset`.
- Reset values: state = ARMED, `interval` = 00, `siren` = 0, `status` = 0, `countdown` = 0, load flag = 0.
- State encodings: ARMED=0, TRIGGERED=1, SOUND=2, DISARMED=3, WAIT_OPEN=4, WAIT_CLOSE=5, ARM_DELAY=6.
- Timer protocol:
  - Every entry into TRIGGERED, SOUND or ARM_DELAY sets `interval` and the load flag in the same edge.
  - In the next cycle the counter loads `value` and the flag clears. Ticks arriving in that load cycle are ignored.
  - After loading, each tick decrements the counter.
  - expire = tick AND `countdown` <= 1 (not in the load cycle). A programmed N gives N ticks; N = 0 behaves as 1 tick.
- `reprogram` = 1 in any state: next state ARMED, `siren` = 0, counter cleared. This has priority over all other transitions.
- ignition = 1 in ARMED, TRIGGERED, SOUND or ARM_DELAY: next state DISARMED. This has priority over door and timer events.
- ARMED:
  - `door_driver` → TRIGGERED, `interval` = 01.
  - Otherwise `door_pass` → TRIGGERED, `interval` = 10. Driver wins when both doors open together.
- TRIGGERED: expire → SOUND, `interval` = 11. Doors closing does not cancel the countdown.
- SOUND:
  - `siren` = 1 registered; asserted from the first cycle in SOUND.
  - Any door open: assert the load flag every cycle, so the alarm is held.
  - Doors closed and expire → ARMED, `siren` = 0.
- DISARMED: ignition = 0 → WAIT_OPEN.
- WAIT_OPEN: ignition = 1 → DISARMED; `door_driver` = 1 → WAIT_CLOSE.
- WAIT_CLOSE: ignition = 1 → DISARMED; `door_driver` = 0 → ARM_DELAY, `interval` = 00.
- ARM_DELAY: any door open → reassert the load flag (restart the delay); expire with doors closed → ARMED.
- `status` LED:
  - ARMED: toggles on each tick (2 s period) and is forced to 0 on entry.
  - TRIGGERED and SOUND: constant 1.
  - All other states: 0.
- Counter: saturates at 0 and never wraps; decrements only on ticks.
- Reset asserted mid-countdown: immediate return to reset values, with no siren glitch.

Test Plan:
- Reset, then open `door_driver` in ARMED with default driver delay 8 → `interval` = 01. `siren` stays 0 for 7 ticks after the load and rises on the cycle after the 8th tick; `interval` = 11.
- In SOUND with alarm delay 10: hold `door_pass` = 1 for 20 ticks → `siren` stays 1. Close the door → `siren` falls to 0 after exactly 10 further ticks; state returns to ARMED.
- Ignition on during TRIGGERED at `countdown` = 3 → DISARMED next cycle, `siren` = 0, `status` = 0. Ignition off, driver door open then closed → ARM_DELAY, `interval` = 00. ARMED after 6 ticks.
- In ARM_DELAY at `countdown` = 2, open `door_pass` → counter reloads to 6. After the door closes, ARMED only after 6 more ticks.
- Program passenger delay = 0 and open `door_pass` → SOUND on the first tick after the load. Open both doors simultaneously in ARMED → `interval` = 01.
- Pulse `reprogram` during SOUND → ARMED next cycle, `siren` = 0. Assert `reset` mid-ARM_DELAY → all outputs at reset values asynchronously.
